// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: datapath width, function codes,
// multiplier FSM states and the registered result/flags bundle.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_NOT = 4'd5;
    localparam logic [3:0] FN_SLL = 4'd6;
    localparam logic [3:0] FN_SRL = 4'd7;
    localparam logic [3:0] FN_SRA = 4'd8;
    localparam logic [3:0] FN_MUL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             carry;
        logic             ovf;
        logic             illegal;
    } alu_res_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Operand-in / result-out handshake bundle of the execute stage.
// slave is the stage itself, master is the surrounding pipeline (or a bench).
interface alu_exec_stage_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_funct;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_funct, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_ovf, out_illegal
    );

    modport master (
        output in_valid, in_funct, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_ovf, out_illegal
    );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU: add/sub with flags, bitwise logic, SLL, final shift mux
// and illegal-code decode. MUL is produced by the stage's own FSM.
module alu_comb
    import alu_pkg::*;
(
    input  logic [3:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] srl_i,
    input  logic [WIDTH-1:0] sra_i,
    output alu_res_t         res_o
);
    localparam int SHW = $clog2(WIDTH);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sll;

    // SUB reuses the adder as A + ~B + 1, so carry-out doubles as A >= B.
    assign is_sub = (funct_i == FN_SUB);
    assign b_eff  = is_sub ? ~b_i : b_i;
    assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign sll    = (|b_i[WIDTH-1:SHW]) ? '0 : (a_i << b_i[SHW-1:0]);

    always_comb begin
        res_o = '0;
        case (funct_i)
            FN_ADD, FN_SUB: begin
                res_o.result = sum[WIDTH-1:0];
                res_o.carry  = sum[WIDTH];
                res_o.ovf    = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                               (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            FN_AND:  res_o.result = a_i & b_i;
            FN_OR:   res_o.result = a_i | b_i;
            FN_XOR:  res_o.result = a_i ^ b_i;
            FN_NOT:  res_o.result = ~a_i;
            FN_SLL:  res_o.result = sll;
            FN_SRL:  res_o.result = srl_i;
            FN_SRA:  res_o.result = sra_i;
            FN_MUL:  res_o.result = '0;
            default: res_o.illegal = 1'b1;
        endcase
        res_o.zero = (res_o.result == '0);
    end

endmodule

// File: rtl/shift_right_arithmetic.sv
// Arithmetic right shift by a full-width amount; amounts >= WIDTH give the
// sign bit replicated across the word.
module shift_right_arithmetic #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] shamt_i,
    output logic [WIDTH-1:0] data_o
);
    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0] stage_v;
    logic                    too_big;

    assign too_big = |shamt_i[WIDTH-1:SHW];

    always_comb begin
        stage_v = $signed(data_i);
        for (int i = 0; i < SHW; i++) begin
            if (shamt_i[i]) begin
                stage_v = stage_v >>> (1 << i);
            end
        end
    end

    assign data_o = too_big ? {WIDTH{data_i[WIDTH-1]}} : stage_v;

endmodule

// File: rtl/shift_right_logical.sv
// Logical right shift by a full-width amount; amounts >= WIDTH give zero.
module shift_right_logical #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] shamt_i,
    output logic [WIDTH-1:0] data_o
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] stage_v;
    logic             too_big;

    assign too_big = |shamt_i[WIDTH-1:SHW];

    // Log-depth barrel: each stage conditionally shifts by a power of two.
    always_comb begin
        stage_v = data_i;
        for (int i = 0; i < SHW; i++) begin
            if (shamt_i[i]) begin
                stage_v = stage_v >> (1 << i);
            end
        end
    end

    assign data_o = too_big ? '0 : stage_v;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle ALU ops with full throughput plus an
// iterative shift-add multiplier, behind valid/ready on both sides.
module alu_exec_stage #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_stage_if.slave   bus
);
    import alu_pkg::*;

    localparam int CW = $clog2(MUL_CYCLES);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    alu_res_t         out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready;
    logic             accept;
    logic             mul_start;
    logic             load_mul;
    logic [WIDTH-1:0] srl_res;
    logic [WIDTH-1:0] sra_res;
    alu_res_t         comb_res;

    shift_right_logical #(.WIDTH(WIDTH)) u_srl (
        .data_i  (bus.in_a),
        .shamt_i (bus.in_b),
        .data_o  (srl_res)
    );

    shift_right_arithmetic #(.WIDTH(WIDTH)) u_sra (
        .data_i  (bus.in_a),
        .shamt_i (bus.in_b),
        .data_o  (sra_res)
    );

    alu_comb u_comb (
        .funct_i (bus.in_funct),
        .a_i     (bus.in_a),
        .b_i     (bus.in_b),
        .srl_i   (srl_res),
        .sra_i   (sra_res),
        .res_o   (comb_res)
    );

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_BUSY;
            ST_BUSY: if (count_q == CW'(MUL_CYCLES - 1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. A slot opens when the output register is empty or draining.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
        accept    = bus.in_valid && in_ready;
        mul_start = accept && (bus.in_funct == FN_MUL);
        load_mul  = (state_q == ST_DONE);
    end

    // Shift-add multiplier datapath: one multiplier bit per BUSY cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (mul_start) begin
            mcand_d  = bus.in_a;
            mplier_d = bus.in_b;
            acc_d    = '0;
            count_d  = '0;
        end else if (state_q == ST_BUSY) begin
            acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

    // Output register: a MUL result never collides with an ALU load because
    // nothing is accepted while the FSM is out of IDLE.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (load_mul) begin
            out_d        = '0;
            out_d.result = acc_q;
            out_d.zero   = (acc_q == '0);
            out_valid_d  = 1'b1;
        end else if (accept && !mul_start) begin
            out_d       = comb_res;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_q.result;
    assign bus.out_zero    = out_q.zero;
    assign bus.out_carry   = out_q.carry;
    assign bus.out_ovf     = out_q.ovf;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: the driver queues hand-computed
// expectations on accept, a negedge monitor checks each retired result.
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_stage_if bus ();

    alu_exec_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;   // {zero, carry, ovf, illegal}
        int          acc_edge;
        int          lat;
        int          fn;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    bit          fresh  = 1'b1;
    int          first_cyc = 0;
    logic [35:0] snap = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, retires on out_valid && out_ready.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            fresh = 1'b1;
        end else begin
            if (bus.out_valid && fresh) begin
                first_cyc = cyc;
                snap      = {bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal};
                fresh     = 1'b0;
            end else if (bus.out_valid) begin
                check("hold_stable",
                      {bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal}, snap);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected no output", bus.out_result);
                end else begin
                    e = sb.pop_front();
                    $display("retire fn=%0d result=%h flags=%b", e.fn, bus.out_result,
                             {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal});
                    check($sformatf("result fn%0d", e.fn), bus.out_result, e.res);
                    check($sformatf("flags fn%0d", e.fn),
                          {bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal}, e.flags);
                    check($sformatf("latency fn%0d", e.fn), first_cyc - e.acc_edge, e.lat);
                end
                fresh = 1'b1;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] fl, input bit push);
        bit   ok = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_funct = f;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", 64'(ok), 64'd1);
        if (ok && push) begin
            e.res      = r;
            e.flags    = fl;
            e.acc_edge = cyc + 1;
            e.lat      = (f == FN_MUL) ? 33 : 0;
            e.fn       = int'(f);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int busy_ready;
        bus.in_valid  = 1'b0;
        bus.in_funct  = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_outputs",
              {bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf, bus.out_illegal}, 36'd0);
        check("reset_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle vectors; flags = {zero, carry, ovf, illegal}.
        issue(FN_SRL, 32'h80000000, 32'd4,        32'h08000000, 4'b0000, 1);
        issue(FN_SRA, 32'h80000000, 32'd4,        32'hF8000000, 4'b0000, 1);
        issue(FN_SRL, 32'h80000000, 32'd32,       32'h00000000, 4'b1000, 1);
        issue(FN_SRA, 32'h80000000, 32'd32,       32'hFFFFFFFF, 4'b0000, 1);
        issue(FN_SRA, 32'h0000FF00, 32'd32,       32'h00000000, 4'b1000, 1);
        issue(FN_SRL, 32'h12345678, 32'd0,        32'h12345678, 4'b0000, 1);
        issue(FN_SRA, 32'h87654321, 32'd0,        32'h87654321, 4'b0000, 1);
        issue(FN_SRA, 32'h87654321, 32'h00010001, 32'hFFFFFFFF, 4'b0000, 1);
        issue(FN_SLL, 32'h00000001, 32'd31,       32'h80000000, 4'b0000, 1);
        issue(FN_SLL, 32'h12345678, 32'd32,       32'h00000000, 4'b1000, 1);
        issue(FN_SLL, 32'h0000ABCD, 32'd8,        32'h00ABCD00, 4'b0000, 1);
        issue(FN_ADD, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0010, 1);
        issue(FN_ADD, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b1100, 1);
        issue(FN_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 4'b1110, 1);
        issue(FN_SUB, 32'd5,        32'd7,        32'hFFFFFFFE, 4'b0000, 1);
        issue(FN_SUB, 32'd7,        32'd5,        32'h00000002, 4'b0100, 1);
        issue(FN_SUB, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0110, 1);
        issue(FN_SUB, 32'd5,        32'd5,        32'h00000000, 4'b1100, 1);
        issue(FN_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0000, 1);
        issue(FN_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b0000, 1);
        issue(FN_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 1);
        issue(FN_NOT, 32'hF0F0F0F0, 32'h12345678, 32'h0F0F0F0F, 4'b0000, 1);
        issue(FN_NOT, 32'hFFFFFFFF, 32'd0,        32'h00000000, 4'b1000, 1);
        issue(4'd12,  32'h00001234, 32'h00005678, 32'h00000000, 4'b1001, 1);
        issue(4'd10,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1001, 1);
        issue(4'd15,  32'h00000001, 32'h00000002, 32'h00000000, 4'b1001, 1);
        drain();

        // MUL latency and in_ready low while the multiplier owns the stage.
        issue(FN_MUL, 32'h00012345, 32'h00000010, 32'h00123450, 4'b0000, 1);
        busy_ready = 0;
        repeat (33) begin
            @(negedge clk);
            if (bus.in_ready) busy_ready++;
        end
        check("mul_busy_in_ready", 64'(busy_ready), 64'd0);
        drain();
        issue(FN_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 1);
        issue(FN_MUL, 32'h00000003, 32'h80000001, 32'h80000003, 4'b0000, 1);
        issue(FN_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1000, 1);
        issue(FN_ADD, 32'd10,       32'd20,       32'd30,       4'b0000, 1);
        drain();

        // Backpressure: first result held, the rest follow in order on release.
        bus.out_ready = 1'b0;
        fork
            begin
                issue(FN_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 1);
                issue(FN_ADD, 32'd2, 32'd2, 32'd4, 4'b0000, 1);
                issue(FN_ADD, 32'd3, 32'd3, 32'd6, 4'b0000, 1);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_in_ready", bus.in_ready, 1'b0);
                check("bp_out_valid", bus.out_valid, 1'b1);
                check("bp_head_result", bus.out_result, 32'd2);
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset during BUSY aborts the multiply without emitting anything.
        issue(FN_MUL, 32'h00000007, 32'h00000009, 32'd63, 4'b0000, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mul_out_valid", bus.out_valid, 1'b0);
        check("rst_mul_in_ready", bus.in_ready, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        issue(FN_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
